// File: rtl/alu_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer_if
// Purpose  : Switch-bus, ALU operand/result and display signals of the sequencer.
// Revision : 1.0
// ============================================================================
interface alu_operand_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] data_in;
    logic         load;
    logic         clear;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [3:0]   sel;
    logic [N-1:0] alu_result;
    logic         alu_of;
    logic         alu_carry;
    logic         alu_cero;
    logic         alu_neg;
    logic [N-1:0] result_q;
    logic         of_q;
    logic         carry_q;
    logic         cero_q;
    logic         neg_q;
    logic         valid;
    logic         op_err;
    logic [2:0]   state;

    modport slave (
        input  data_in, load, clear, alu_result, alu_of, alu_carry, alu_cero, alu_neg,
        output A, B, sel, result_q, of_q, carry_q, cero_q, neg_q, valid, op_err, state
    );

    modport master (
        output data_in, load, clear, alu_result, alu_of, alu_carry, alu_cero, alu_neg,
        input  A, B, sel, result_q, of_q, carry_q, cero_q, neg_q, valid, op_err, state
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_sequencer
// Purpose  : Serially loads A, B and op code for the ALU; latches its result.
// Revision : 1.0
// ============================================================================
module alu_operand_sequencer #(
    parameter int N = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    alu_operand_sequencer_if.slave        bus
);
    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } state_t;

    localparam logic [3:0] C_LAST_OP = 4'b0101;

    state_t       state_q, state_d;
    logic         s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]   sel_q, sel_d;
    logic         of_q, of_d, carry_q, carry_d, cero_q, cero_d, neg_q, neg_d;
    logic         valid_q, valid_d, op_err_q, op_err_d;
    logic         press;
    logic [3:0]   op_in;

    generate
        if (N >= 4) begin : g_op_wide
            assign op_in = bus.data_in[3:0];
        end else begin : g_op_narrow
            assign op_in = {{(4-N){1'b0}}, bus.data_in};
        end
    endgenerate

    // s1/s2 resynchronise the asynchronous button; s3 turns its level into one pulse.
    assign s1_d  = bus.load;
    assign s2_d  = s1_q;
    assign s3_d  = s2_q;
    assign press = s2_q & ~s3_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        res_d    = res_q;
        of_d     = of_q;
        carry_d  = carry_q;
        cero_d   = cero_q;
        neg_d    = neg_q;
        valid_d  = valid_q;
        op_err_d = op_err_q;

        if (bus.clear) begin
            state_d  = GET_A;
            a_d      = '0;
            b_d      = '0;
            sel_d    = '0;
            res_d    = '0;
            of_d     = 1'b0;
            carry_d  = 1'b0;
            cero_d   = 1'b0;
            neg_d    = 1'b0;
            valid_d  = 1'b0;
            op_err_d = 1'b0;
        end else begin
            case (state_q)
                GET_A: if (press) begin
                    a_d     = bus.data_in;
                    state_d = GET_B;
                end
                GET_B: if (press) begin
                    b_d     = bus.data_in;
                    state_d = GET_OP;
                end
                GET_OP: if (press) begin
                    sel_d   = op_in;
                    state_d = EXEC;
                end
                EXEC: begin
                    res_d    = bus.alu_result;
                    of_d     = bus.alu_of;
                    carry_d  = bus.alu_carry;
                    cero_d   = bus.alu_cero;
                    neg_d    = bus.alu_neg;
                    op_err_d = (sel_q > C_LAST_OP);
                    valid_d  = 1'b1;
                    state_d  = SHOW;
                end
                // A press here doubles as the operand-A load of the next sequence.
                SHOW: if (press) begin
                    a_d      = bus.data_in;
                    valid_d  = 1'b0;
                    op_err_d = 1'b0;
                    state_d  = GET_B;
                end
                default: state_d = GET_A;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= GET_A;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            res_q    <= '0;
            of_q     <= 1'b0;
            carry_q  <= 1'b0;
            cero_q   <= 1'b0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            res_q    <= res_d;
            of_q     <= of_d;
            carry_q  <= carry_d;
            cero_q   <= cero_d;
            neg_q    <= neg_d;
            valid_q  <= valid_d;
            op_err_q <= op_err_d;
        end
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.sel      = sel_q;
    assign bus.result_q = res_q;
    assign bus.of_q     = of_q;
    assign bus.carry_q  = carry_q;
    assign bus.cero_q   = cero_q;
    assign bus.neg_q    = neg_q;
    assign bus.valid    = valid_q;
    assign bus.op_err   = op_err_q;
    assign bus.state    = state_q;

endmodule
`default_nettype wire
